sincos_nco: RTL and testbench

SINCOS_NCO -- requirements
Module: sincos_nco

---
 rtl/sincos_nco_pkg.sv | 43 ++++
 rtl/sincos_nco_qtr_rom.sv | 54 +++++
 rtl/sincos_nco.sv | 160 ++++++++++++++++
 tb/tb_sincos_nco.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sincos_nco_pkg.sv
// Shared definitions for the sine/cosine NCO: default widths, quadrant
// encoding and the elaboration-time generator for the quarter-wave table.
package sincos_nco_pkg;

  localparam int PW_DEF = 17;
  localparam int OW_DEF = 13;
  localparam int TW_DEF = 10;

  // Top two phase bits select the quadrant of the circle.
  typedef enum logic [1:0] {
    Q0 = 2'd0,
    Q1 = 2'd1,
    Q2 = 2'd2,
    Q3 = 2'd3
  } quad_e;

  // Fixed-point scale for the table generator; 30 fractional bits keeps
  // every intermediate product of the series inside a signed 64-bit value.
  localparam int     FX    = 30;
  localparam longint PI_FX = 64'sd3373259426;

  // Quarter-table entry k: round(amp * sin(pi * (2k+1) / 2^tw)) with
  // amp = 2^(ow-1)-1. Evaluated with an integer Taylor series so the table
  // is built at elaboration without any real-valued arithmetic.
  function automatic int qtr_entry(input int k, input int tw, input int ow);
    longint x;
    longint x2;
    longint term;
    longint sum;
    longint amp;
    x    = (PI_FX * longint'(2 * k + 1)) >>> tw;
    x2   = (x * x) >>> FX;
    term = x;
    sum  = x;
    for (int n = 1; n <= 8; n++) begin
      term = -((term * x2) >>> FX) / longint'((2 * n) * (2 * n + 1));
      sum  = sum + term;
    end
    amp = (longint'(1) <<< (ow - 1)) - 1;
    return int'((sum * amp + (longint'(1) <<< (FX - 1))) >>> FX);
  endfunction

endpackage

// File: rtl/sincos_nco_qtr_rom.sv
// Quarter-wave sine magnitude table with two registered read ports.
// Contents are generated at elaboration from the package generator, so the
// table always matches the TW/OW the parent is built with.
module sincos_qtr_rom
  import sincos_nco_pkg::*;
#(
  parameter int TW = TW_DEF,
  parameter int OW = OW_DEF
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_ce,
  input  logic [TW-3:0] i_addr_a,
  input  logic [TW-3:0] i_addr_b,
  output logic [OW-2:0] o_data_a,
  output logic [OW-2:0] o_data_b
);

  localparam int DEPTH = 1 << (TW - 2);

  logic [OW-2:0] rom_w [DEPTH];
  logic [OW-2:0] data_a_q, data_a_d;
  logic [OW-2:0] data_b_q, data_b_d;

  for (genvar k = 0; k < DEPTH; k++) begin : g_entry
    localparam int ENTRY = qtr_entry(k, TW, OW);
    assign rom_w[k] = ENTRY[OW-2:0];
  end

  // Read both ports when enabled, otherwise hold the last words.
  always_comb begin
    data_a_d = data_a_q;
    data_b_d = data_b_q;
    if (i_ce) begin
      data_a_d = rom_w[i_addr_a];
      data_b_d = rom_w[i_addr_b];
    end
  end

  // Read registers, cleared by synchronous reset.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      data_a_q <= '0;
      data_b_q <= '0;
    end else begin
      data_a_q <= data_a_d;
      data_b_q <= data_b_d;
    end
  end

  assign o_data_a = data_a_q;
  assign o_data_b = data_b_q;

endmodule

// File: rtl/sincos_nco.sv
// Sine/cosine numerically controlled oscillator.
// Pipeline: accumulate + offset -> quadrant fold -> table read -> sign.
// A phase sampled on one enabled edge reaches the outputs three enabled
// edges later; everything holds while i_ce is low.
module sincos_nco
  import sincos_nco_pkg::*;
#(
  parameter int PW = PW_DEF,
  parameter int OW = OW_DEF,
  parameter int TW = TW_DEF
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_ce,
  input  logic          i_freq_wr,
  input  logic [PW-1:0] i_freq,
  input  logic [PW-1:0] i_phase_off,
  input  logic          i_aux,
  output logic [OW-1:0] o_sin,
  output logic [OW-1:0] o_cos,
  output logic          o_aux
);

  logic [PW-1:0]   acc_q, acc_d;
  logic [PW-1:0]   step_q, step_d;
  logic [TW-1:0]   p1_q, p1_d;
  logic [PW-TW:0]  frac_unused;
  logic            aux1_q, aux1_d;

  quad_e           q_s, q_c;
  logic [TW-3:0]   k;
  logic [TW-3:0]   ks_q, ks_d, kc_q, kc_d;
  logic            sneg2_q, sneg2_d, cneg2_q, cneg2_d;
  logic            aux2_q, aux2_d;

  logic [OW-2:0]   mag_s, mag_c;
  logic            sneg3_q, sneg3_d, cneg3_q, cneg3_d;
  logic            aux3_q, aux3_d;

  logic [OW-1:0]   mag_s_ext, mag_c_ext;
  logic [OW-1:0]   sin_q, sin_d, cos_q, cos_d;
  logic            aux4_q, aux4_d;

  // Step register loads regardless of i_ce; accumulator uses the step held
  // before any same-cycle load. Phase bits below the table resolution are
  // dropped here; the padding bit keeps the split legal when TW == PW.
  always_comb begin
    step_d      = i_freq_wr ? i_freq : step_q;
    acc_d       = acc_q;
    p1_d        = p1_q;
    aux1_d      = aux1_q;
    frac_unused = '0;
    if (i_ce) begin
      acc_d                = acc_q + step_q;
      {p1_d, frac_unused}  = {acc_q + i_phase_off, 1'b0};
      aux1_d               = i_aux;
    end
  end

  // Fold the phase into a quarter-table index and a sign per output;
  // cosine is sine advanced by one quadrant.
  always_comb begin
    q_s     = quad_e'(p1_q[TW-1:TW-2]);
    q_c     = quad_e'(p1_q[TW-1:TW-2] + 2'd1);
    k       = p1_q[TW-3:0];
    ks_d    = ks_q;
    kc_d    = kc_q;
    sneg2_d = sneg2_q;
    cneg2_d = cneg2_q;
    aux2_d  = aux2_q;
    if (i_ce) begin
      ks_d    = ((q_s == Q1) || (q_s == Q3)) ? ~k : k;
      kc_d    = ((q_c == Q1) || (q_c == Q3)) ? ~k : k;
      sneg2_d = (q_s == Q2) || (q_s == Q3);
      cneg2_d = (q_c == Q2) || (q_c == Q3);
      aux2_d  = aux1_q;
    end
  end

  sincos_qtr_rom #(
    .TW (TW),
    .OW (OW)
  ) u_rom (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_ce      (i_ce),
    .i_addr_a  (ks_q),
    .i_addr_b  (kc_q),
    .o_data_a  (mag_s),
    .o_data_b  (mag_c)
  );

  // Carry sign flags and aux alongside the table read.
  always_comb begin
    sneg3_d = sneg3_q;
    cneg3_d = cneg3_q;
    aux3_d  = aux3_q;
    if (i_ce) begin
      sneg3_d = sneg2_q;
      cneg3_d = cneg2_q;
      aux3_d  = aux2_q;
    end
  end

  // Apply sign; magnitudes are at most 2^(OW-1)-1 so negation cannot overflow.
  always_comb begin
    mag_s_ext = {1'b0, mag_s};
    mag_c_ext = {1'b0, mag_c};
    sin_d     = sin_q;
    cos_d     = cos_q;
    aux4_d    = aux4_q;
    if (i_ce) begin
      sin_d  = sneg3_q ? -mag_s_ext : mag_s_ext;
      cos_d  = cneg3_q ? -mag_c_ext : mag_c_ext;
      aux4_d = aux3_q;
    end
  end

  // All state registers; synchronous reset overrides enable and step load.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      acc_q   <= '0;
      step_q  <= '0;
      p1_q    <= '0;
      aux1_q  <= 1'b0;
      ks_q    <= '0;
      kc_q    <= '0;
      sneg2_q <= 1'b0;
      cneg2_q <= 1'b0;
      aux2_q  <= 1'b0;
      sneg3_q <= 1'b0;
      cneg3_q <= 1'b0;
      aux3_q  <= 1'b0;
      sin_q   <= '0;
      cos_q   <= '0;
      aux4_q  <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      step_q  <= step_d;
      p1_q    <= p1_d;
      aux1_q  <= aux1_d;
      ks_q    <= ks_d;
      kc_q    <= kc_d;
      sneg2_q <= sneg2_d;
      cneg2_q <= cneg2_d;
      aux2_q  <= aux2_d;
      sneg3_q <= sneg3_d;
      cneg3_q <= cneg3_d;
      aux3_q  <= aux3_d;
      sin_q   <= sin_d;
      cos_q   <= cos_d;
      aux4_q  <= aux4_d;
    end
  end

  assign o_sin = sin_q;
  assign o_cos = cos_q;
  assign o_aux = aux4_q;

endmodule

// File: tb/tb_sincos_nco.sv
// Self-checking bench for sincos_nco (PW=17, OW=13, TW=10).
// A behavioural accumulator produces the expected sample for every enabled
// edge; expectations queue up and are retired once the pipeline has filled.
module tb_sincos_nco;

  localparam int PW = 17;
  localparam int OW = 13;
  localparam int TW = 10;
  localparam real PI_R = 3.14159265358979323846;

  logic                 i_clk = 1'b0;
  logic                 i_reset_n;
  logic                 i_ce;
  logic                 i_freq_wr;
  logic [PW-1:0]        i_freq;
  logic [PW-1:0]        i_phase_off;
  logic                 i_aux;
  logic signed [OW-1:0] o_sin;
  logic signed [OW-1:0] o_cos;
  logic                 o_aux;

  typedef struct {
    logic signed [OW-1:0] s;
    logic signed [OW-1:0] c;
    logic                 a;
    int                   idx;
  } exp_t;

  exp_t          sbq[$];
  exp_t          last_e;
  bit            have_last;
  int            n_vec;
  int            n_err;
  int            n_samp;
  logic [PW-1:0] acc_m;
  logic [PW-1:0] step_m;

  always #5 i_clk = ~i_clk;

  sincos_nco #(.PW(PW), .OW(OW), .TW(TW)) dut (
    .i_clk       (i_clk),
    .i_reset_n   (i_reset_n),
    .i_ce        (i_ce),
    .i_freq_wr   (i_freq_wr),
    .i_freq      (i_freq),
    .i_phase_off (i_phase_off),
    .i_aux       (i_aux),
    .o_sin       (o_sin),
    .o_cos       (o_cos),
    .o_aux       (o_aux)
  );

  // Ideal wave at the centre of the truncated phase bin, rounded half away from zero.
  function automatic logic signed [OW-1:0] ref_wave(input logic [PW-1:0] ph, input bit is_cos);
    int  m;
    int  r;
    real a;
    real v;
    m = int'(ph[PW-1:PW-TW]);
    a = 2.0 * PI_R * (real'(m) + 0.5) / real'(1 << TW);
    v = 4095.0 * (is_cos ? $cos(a) : $sin(a));
    r = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
    return OW'(r);
  endfunction

  // One clock: update the model from the inputs seen at the edge, then
  // return the expectation retired at this edge (if any), 1 ns after it.
  task automatic cycle(output bit vld, output exp_t e);
    exp_t          n;
    logic [PW-1:0] ph;
    vld   = 1'b0;
    e.s   = '0;
    e.c   = '0;
    e.a   = 1'b0;
    e.idx = -1;
    @(posedge i_clk);
    if (!i_reset_n) begin
      acc_m     = '0;
      step_m    = '0;
      n_samp    = 0;
      have_last = 1'b0;
      sbq.delete();
    end else begin
      if (i_ce) begin
        ph    = acc_m + i_phase_off;
        n.s   = ref_wave(ph, 1'b0);
        n.c   = ref_wave(ph, 1'b1);
        n.a   = i_aux;
        n.idx = n_samp;
        n_samp++;
        sbq.push_back(n);
        acc_m = acc_m + step_m;
        if (sbq.size() > 3) begin
          e         = sbq.pop_front();
          vld       = 1'b1;
          last_e    = e;
          have_last = 1'b1;
        end
      end
      if (i_freq_wr) step_m = i_freq;
    end
    #1;
  endtask

  task automatic test_reset();
    bit   v;
    exp_t e;
    i_reset_n   = 1'b0;
    i_ce        = 1'b1;
    i_aux       = 1'b1;
    i_freq_wr   = 1'b1;
    i_freq      = 17'h1ABCD;
    i_phase_off = 17'h05555;
    for (int i = 0; i < 3; i++) begin
      cycle(v, e);
      n_vec++;
      if ({o_sin, o_cos, o_aux} !== 27'd0) begin
        n_err++;
        $display("FAIL reset[%0d]: got sin=%0d cos=%0d aux=%0b, want 0 0 0", i, o_sin, o_cos, o_aux);
      end
    end
    i_reset_n   = 1'b1;
    i_freq_wr   = 1'b0;
    i_freq      = '0;
    i_phase_off = '0;
  endtask

  task automatic test_dc();
    bit   v;
    exp_t e;
    i_ce  = 1'b1;
    i_aux = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle(v, e);
      if (v) begin
        n_vec++;
        if (o_sin !== e.s || o_cos !== e.c || o_aux !== e.a) begin
          n_err++;
          $display("FAIL dc[%0d]: got %0d/%0d/%0b want %0d/%0d/%0b", e.idx, o_sin, o_cos, o_aux, e.s, e.c, e.a);
        end
      end
    end
    n_vec++;
    if (o_sin !== 13'sd13 || o_cos !== 13'sd4095 || o_aux !== 1'b1) begin
      n_err++;
      $display("FAIL dc_const: got %0d/%0d/%0b want 13/4095/1", o_sin, o_cos, o_aux);
    end
  endtask

  task automatic test_offset90();
    bit   v;
    exp_t e;
    i_phase_off = 17'h08000;
    for (int i = 0; i < 6; i++) begin
      cycle(v, e);
      if (v) begin
        n_vec++;
        if (o_sin !== e.s || o_cos !== e.c || o_aux !== e.a) begin
          n_err++;
          $display("FAIL offset90[%0d]: got %0d/%0d/%0b want %0d/%0d/%0b", e.idx, o_sin, o_cos, o_aux, e.s, e.c, e.a);
        end
      end
    end
    n_vec++;
    if (o_sin !== 13'sd4095 || o_cos !== 13'h1FF3) begin
      n_err++;
      $display("FAIL offset90_const: got %0d/%0d want 4095/-13", o_sin, o_cos);
    end
    i_phase_off = '0;
  endtask

  task automatic test_sweep();
    bit   v;
    exp_t e;
    i_reset_n = 1'b0;
    cycle(v, e);
    i_reset_n = 1'b1;
    i_ce      = 1'b0;
    i_freq_wr = 1'b1;
    i_freq    = 17'h00400;
    cycle(v, e);
    i_freq_wr = 1'b0;
    i_ce      = 1'b1;
    for (int i = 0; i < 135; i++) begin
      i_aux = i[0];
      cycle(v, e);
      if (v) begin
        n_vec++;
        if (o_sin !== e.s || o_cos !== e.c || o_aux !== e.a) begin
          n_err++;
          $display("FAIL sweep[%0d]: got %0d/%0d/%0b want %0d/%0d/%0b", e.idx, o_sin, o_cos, o_aux, e.s, e.c, e.a);
        end
        if (e.idx == 32) begin
          n_vec++;
          if (o_sin !== 13'sd4095) begin
            n_err++;
            $display("FAIL sweep_s32: got %0d want 4095", o_sin);
          end
        end
        if (e.idx == 64) begin
          n_vec++;
          if (o_sin !== 13'h1FF3) begin
            n_err++;
            $display("FAIL sweep_s64: got %0d want -13", o_sin);
          end
        end
        if (e.idx == 128) begin
          n_vec++;
          if (o_sin !== 13'sd13 || o_cos !== 13'sd4095) begin
            n_err++;
            $display("FAIL sweep_wrap: got %0d/%0d want 13/4095", o_sin, o_cos);
          end
        end
      end
    end
  endtask

  task automatic test_freeze();
    bit   v;
    exp_t e;
    i_ce = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle(v, e);
      if (v) begin
        n_vec++;
        if (o_sin !== e.s || o_cos !== e.c || o_aux !== e.a) begin
          n_err++;
          $display("FAIL pre_freeze[%0d]: got %0d/%0d/%0b want %0d/%0d/%0b", e.idx, o_sin, o_cos, o_aux, e.s, e.c, e.a);
        end
      end
    end
    i_ce = 1'b0;
    for (int i = 0; i < 10; i++) begin
      i_freq_wr   = (i == 3);
      i_freq      = 17'h01000;
      i_aux       = ~i_aux;
      i_phase_off = 17'(i * 17'h00321);
      cycle(v, e);
      n_vec++;
      if (o_sin !== last_e.s || o_cos !== last_e.c || o_aux !== last_e.a) begin
        n_err++;
        $display("FAIL freeze[%0d]: got %0d/%0d/%0b want %0d/%0d/%0b", i, o_sin, o_cos, o_aux, last_e.s, last_e.c, last_e.a);
      end
    end
    i_freq_wr   = 1'b0;
    i_phase_off = '0;
    i_ce        = 1'b1;
    for (int i = 0; i < 12; i++) begin
      cycle(v, e);
      if (v) begin
        n_vec++;
        if (o_sin !== e.s || o_cos !== e.c || o_aux !== e.a) begin
          n_err++;
          $display("FAIL resume[%0d]: got %0d/%0d/%0b want %0d/%0d/%0b", e.idx, o_sin, o_cos, o_aux, e.s, e.c, e.a);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    bit   v;
    exp_t e;
    i_ce      = 1'b1;
    i_reset_n = 1'b0;
    cycle(v, e);
    n_vec++;
    if ({o_sin, o_cos, o_aux} !== 27'd0) begin
      n_err++;
      $display("FAIL reset_mid: got %0d/%0d/%0b want 0/0/0", o_sin, o_cos, o_aux);
    end
    i_reset_n   = 1'b1;
    i_phase_off = '0;
    i_aux       = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cycle(v, e);
      if (v) begin
        n_vec++;
        if (o_sin !== e.s || o_cos !== e.c || o_aux !== e.a) begin
          n_err++;
          $display("FAIL refill[%0d]: got %0d/%0d/%0b want %0d/%0d/%0b", e.idx, o_sin, o_cos, o_aux, e.s, e.c, e.a);
        end
      end
    end
    n_vec++;
    if (o_sin !== 13'sd13 || o_cos !== 13'sd4095 || o_aux !== 1'b1) begin
      n_err++;
      $display("FAIL refill_const: got %0d/%0d/%0b want 13/4095/1", o_sin, o_cos, o_aux);
    end
  endtask

  task automatic test_back_to_back();
    bit   v;
    exp_t e;
    for (int i = 0; i < 300; i++) begin
      i_ce        = ($urandom_range(0, 3) != 0);
      i_freq_wr   = ($urandom_range(0, 15) == 0);
      i_freq      = 17'($urandom);
      i_phase_off = 17'($urandom);
      i_aux       = 1'($urandom);
      cycle(v, e);
      if (v) begin
        n_vec++;
        if (o_sin !== e.s || o_cos !== e.c || o_aux !== e.a) begin
          n_err++;
          $display("FAIL random[%0d]: got %0d/%0d/%0b want %0d/%0d/%0b", e.idx, o_sin, o_cos, o_aux, e.s, e.c, e.a);
        end
      end else if (!i_ce && have_last) begin
        n_vec++;
        if (o_sin !== last_e.s || o_cos !== last_e.c || o_aux !== last_e.a) begin
          n_err++;
          $display("FAIL random_hold[%0d]: got %0d/%0d/%0b want %0d/%0d/%0b", i, o_sin, o_cos, o_aux, last_e.s, last_e.c, last_e.a);
        end
      end
    end
    i_freq_wr = 1'b0;
  endtask

  initial begin
    n_vec       = 0;
    n_err       = 0;
    n_samp      = 0;
    acc_m       = '0;
    step_m      = '0;
    have_last   = 1'b0;
    i_reset_n   = 1'b1;
    i_ce        = 1'b0;
    i_freq_wr   = 1'b0;
    i_freq      = '0;
    i_phase_off = '0;
    i_aux       = 1'b0;
    test_reset();
    test_dc();
    test_offset90();
    test_sweep();
    test_freeze();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
